// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the bus-datapath control unit: opcodes, FSM states,
// strobe bit positions and the opcode classifier used by the sequencer.
package cpu_defs;

    localparam logic [4:0] INC_OP  = 5'b11111;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // T-states are consecutive so step = state - ST_T0
    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    localparam int SRC_HI   = 0;
    localparam int SRC_LO   = 1;
    localparam int SRC_ZHI  = 2;
    localparam int SRC_ZLO  = 3;
    localparam int SRC_PC   = 4;
    localparam int SRC_MDR  = 5;
    localparam int SRC_INP  = 6;
    localparam int SRC_RAM  = 7;

    localparam int DST_HI   = 0;
    localparam int DST_LO   = 1;
    localparam int DST_ZHI  = 2;
    localparam int DST_ZLO  = 3;
    localparam int DST_PC   = 4;
    localparam int DST_MDR  = 5;
    localparam int DST_OUTP = 6;
    localparam int DST_Y    = 7;
    localparam int DST_MAR  = 8;

    typedef enum logic [2:0] {
        CL_ALU, CL_MULDIV, CL_LD, CL_ST, CL_SINGLE, CL_HALT, CL_ILL
    } op_class_e;

    function automatic op_class_e classify(input logic [4:0] opc);
        case (opc)
            OP_LD:                                  return CL_LD;
            OP_ST:                                  return CL_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL:         return CL_ALU;
            OP_MUL, OP_DIV:                         return CL_MULDIV;
            OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP: return CL_SINGLE;
            OP_HALT:                                return CL_HALT;
            default:                                return CL_ILL;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_reg_decode.sv
// Gated 4-to-16 one-hot register select decoder.
module reg_decode_4to16 (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] oh
);
    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign oh[i] = en && (sel == 4'(i));
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore sequencer: fetches into IR, then steps T3..T6 per opcode class,
// driving the datapath strobes combinationally from state and IR.
module control_sequencer #(
    parameter int              OP_W   = 5,
    parameter logic [OP_W-1:0] INC_OP = 5'b11111
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     BusMuxOut,
    output logic [15:0]     Rout,
    output logic [15:0]     Rin,
    output logic [7:0]      srcOut,
    output logic [8:0]      dstIn,
    output logic            Read,
    output logic            Write,
    output logic            BAOut,
    output logic [OP_W-1:0] op,
    output logic            run,
    output logic            illegal,
    output logic [2:0]      step
);
    import cpu_defs::*;

    logic [3:0]  state, nxt;
    logic [31:0] ir;

    logic [4:0]  opc;
    logic [3:0]  ra, rb, rc;
    op_class_e   cls;

    assign opc = ir[31:27];
    assign ra  = ir[26:23];
    assign rb  = ir[22:19];
    assign rc  = ir[18:15];
    assign cls = classify(opc);

    logic unused_ir;
    assign unused_ir = ^ir[14:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_RST;
            ir    <= '0;
        end else begin
            state <= nxt;
            if (state == ST_T2) ir <= BusMuxOut;
        end
    end

    always_comb begin
        nxt = ST_RST;
        case (state)
            ST_RST:  nxt = ST_T0;
            ST_T0:   nxt = ST_T1;
            ST_T1:   nxt = ST_T2;
            ST_T2:   nxt = ST_T3;
            ST_T3: begin
                case (cls)
                    CL_HALT:                          nxt = ST_HALT;
                    CL_ALU, CL_MULDIV, CL_LD, CL_ST:  nxt = ST_T4;
                    default:                          nxt = ST_T0;
                endcase
            end
            ST_T4:   nxt = (cls == CL_ST) ? ST_T0 : ST_T5;
            ST_T5:   nxt = (cls == CL_MULDIV) ? ST_T6 : ST_T0;
            ST_T6:   nxt = ST_T0;
            ST_HALT: nxt = ST_HALT;
            default: nxt = ST_RST;
        endcase
    end

    // Decoder lanes: 0 = Ra out, 1 = Rb out, 2 = Rc out, 3 = Ra in
    logic [3:0]        dec_en;
    logic [3:0][3:0]   dec_sel;
    logic [3:0][15:0]  dec_oh;

    assign dec_sel = {ra, rc, rb, ra};

    for (genvar i = 0; i < 4; i++) begin : g_dec
        reg_decode_4to16 u_dec (
            .en  (dec_en[i]),
            .sel (dec_sel[i]),
            .oh  (dec_oh[i])
        );
    end

    assign Rout = dec_oh[0] | dec_oh[1] | dec_oh[2];
    assign Rin  = dec_oh[3];

    always_comb begin
        dec_en  = '0;
        srcOut  = '0;
        dstIn   = '0;
        Read    = 1'b0;
        Write   = 1'b0;
        BAOut   = 1'b0;
        op      = '0;
        illegal = 1'b0;
        case (state)
            ST_T0: begin
                srcOut[SRC_PC]  = 1'b1;
                dstIn[DST_MAR]  = 1'b1;
                dstIn[DST_ZLO]  = 1'b1;
                op              = INC_OP;
            end
            ST_T1: begin
                srcOut[SRC_ZLO] = 1'b1;
                dstIn[DST_PC]   = 1'b1;
                Read            = 1'b1;
            end
            ST_T2: srcOut[SRC_RAM] = 1'b1;
            ST_T3: begin
                case (cls)
                    CL_ALU: begin
                        dec_en[1]    = 1'b1;
                        dstIn[DST_Y] = 1'b1;
                    end
                    CL_MULDIV: begin
                        dec_en[0]    = 1'b1;
                        dstIn[DST_Y] = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        dec_en[1]      = 1'b1;
                        BAOut          = 1'b1;
                        dstIn[DST_MAR] = 1'b1;
                    end
                    CL_SINGLE: begin
                        case (opc)
                            OP_IN: begin
                                srcOut[SRC_INP] = 1'b1;
                                dec_en[3]       = 1'b1;
                            end
                            OP_OUT: begin
                                dec_en[0]       = 1'b1;
                                dstIn[DST_OUTP] = 1'b1;
                            end
                            OP_MFHI: begin
                                srcOut[SRC_HI] = 1'b1;
                                dec_en[3]      = 1'b1;
                            end
                            OP_MFLO: begin
                                srcOut[SRC_LO] = 1'b1;
                                dec_en[3]      = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    CL_ILL:  illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_ALU: begin
                        dec_en[2]      = 1'b1;
                        op             = OP_W'(opc);
                        dstIn[DST_ZLO] = 1'b1;
                    end
                    CL_MULDIV: begin
                        dec_en[1]      = 1'b1;
                        op             = OP_W'(opc);
                        dstIn[DST_ZLO] = 1'b1;
                        dstIn[DST_ZHI] = 1'b1;
                    end
                    CL_LD: Read = 1'b1;
                    CL_ST: begin
                        dec_en[0] = 1'b1;
                        Write     = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_ALU: begin
                        srcOut[SRC_ZLO] = 1'b1;
                        dec_en[3]       = 1'b1;
                    end
                    CL_MULDIV: begin
                        srcOut[SRC_ZLO] = 1'b1;
                        dstIn[DST_LO]   = 1'b1;
                    end
                    CL_LD: begin
                        srcOut[SRC_RAM] = 1'b1;
                        dec_en[3]       = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (cls == CL_MULDIV) begin
                    srcOut[SRC_ZHI] = 1'b1;
                    dstIn[DST_HI]   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign run  = (state != ST_RST) && (state != ST_HALT);
    assign step = (state >= ST_T0 && state <= ST_T6) ? 3'(state - ST_T0) : 3'd0;

    // Only one driver may own the shared bus in any cycle
    a_bus_onehot: assert property (@(posedge clock) disable iff (clear)
        $onehot0({Rout, srcOut}));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer: table of per-cycle expected strobes
// plus hand sequences for async clear mid-instruction and halt.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] BusMuxOut;
    logic [15:0] Rout, Rin;
    logic [7:0]  srcOut;
    logic [8:0]  dstIn;
    logic        Read, Write, BAOut, run, illegal;
    logic [4:0]  op;
    logic [2:0]  step;

    control_sequencer dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut),
        .Rout(Rout), .Rin(Rin), .srcOut(srcOut), .dstIn(dstIn),
        .Read(Read), .Write(Write), .BAOut(BAOut), .op(op),
        .run(run), .illegal(illegal), .step(step)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic [7:0]  src;
        logic [8:0]  dst;
        logic        rd;
        logic        wr;
        logic        ba;
        logic [4:0]  op;
        logic        run;
        logic        ill;
        logic [2:0]  step;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] bus;
        outs_t       exp;
    } vec_t;

    outs_t act;
    assign act = {Rout, Rin, srcOut, dstIn, Read, Write, BAOut, op, run, illegal, step};

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam outs_t ZERO = '0;

    function automatic outs_t mk(logic [15:0] rout, logic [15:0] rin, logic [7:0] src,
                                 logic [8:0] dst, logic rd, logic wr, logic ba,
                                 logic [4:0] o, logic r, logic ill, logic [2:0] s);
        outs_t x;
        x = '{rout, rin, src, dst, rd, wr, ba, o, r, ill, s};
        return x;
    endfunction

    function automatic string fmt(outs_t x);
        return $sformatf("rout=%h rin=%h src=%h dst=%h rd=%b wr=%b ba=%b op=%h run=%b ill=%b step=%0d",
                         x.rout, x.rin, x.src, x.dst, x.rd, x.wr, x.ba, x.op, x.run, x.ill, x.step);
    endfunction

    task automatic check(string nm, outs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {%s} want {%s}", nm, fmt(act), fmt(exp));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(string nm, logic [31:0] bus, outs_t e);
        vec_t v;
        v.name = nm;
        v.bus  = bus;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    outs_t T0_EXP, T1_EXP, T2_EXP;

    task automatic fetch(string nm, logic [31:0] bus);
        push({nm, "_t0"}, bus, T0_EXP);
        push({nm, "_t1"}, bus, T1_EXP);
        push({nm, "_t2"}, bus, T2_EXP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        T0_EXP = mk(16'h0, 16'h0, 8'h10, 9'h108, 0, 0, 0, 5'h1f, 1, 0, 3'd0);
        T1_EXP = mk(16'h0, 16'h0, 8'h08, 9'h010, 1, 0, 0, 5'h00, 1, 0, 3'd1);
        T2_EXP = mk(16'h0, 16'h0, 8'h80, 9'h000, 0, 0, 0, 5'h00, 1, 0, 3'd2);

        // add Ra=2 Rb=2 Rc=0
        fetch("add", 32'h1910_0000);
        push("add_t3", 32'h1910_0000, mk(16'h0004, 16'h0, 8'h00, 9'h080, 0, 0, 0, 5'h00, 1, 0, 3'd3));
        push("add_t4", 32'h1910_0000, mk(16'h0001, 16'h0, 8'h00, 9'h008, 0, 0, 0, 5'h03, 1, 0, 3'd4));
        push("add_t5", 32'h1910_0000, mk(16'h0000, 16'h0004, 8'h08, 9'h000, 0, 0, 0, 5'h00, 1, 0, 3'd5));
        // ld Ra=1 Rb=0
        fetch("ld", 32'h0080_0000);
        push("ld_t3", 32'h0080_0000, mk(16'h0001, 16'h0, 8'h00, 9'h100, 0, 0, 1, 5'h00, 1, 0, 3'd3));
        push("ld_t4", 32'h0080_0000, mk(16'h0000, 16'h0, 8'h00, 9'h000, 1, 0, 0, 5'h00, 1, 0, 3'd4));
        push("ld_t5", 32'h0080_0000, mk(16'h0000, 16'h0002, 8'h80, 9'h000, 0, 0, 0, 5'h00, 1, 0, 3'd5));
        // mul Ra=4 Rb=4
        fetch("mul", 32'h7220_0000);
        push("mul_t3", 32'h7220_0000, mk(16'h0010, 16'h0, 8'h00, 9'h080, 0, 0, 0, 5'h00, 1, 0, 3'd3));
        push("mul_t4", 32'h7220_0000, mk(16'h0010, 16'h0, 8'h00, 9'h00C, 0, 0, 0, 5'h0E, 1, 0, 3'd4));
        push("mul_t5", 32'h7220_0000, mk(16'h0000, 16'h0, 8'h08, 9'h002, 0, 0, 0, 5'h00, 1, 0, 3'd5));
        push("mul_t6", 32'h7220_0000, mk(16'h0000, 16'h0, 8'h04, 9'h001, 0, 0, 0, 5'h00, 1, 0, 3'd6));
        // st Ra=5 Rb=6
        fetch("st", 32'h0AB0_0000);
        push("st_t3", 32'h0AB0_0000, mk(16'h0040, 16'h0, 8'h00, 9'h100, 0, 0, 1, 5'h00, 1, 0, 3'd3));
        push("st_t4", 32'h0AB0_0000, mk(16'h0020, 16'h0, 8'h00, 9'h000, 0, 1, 0, 5'h00, 1, 0, 3'd4));
        // in R7
        fetch("in", 32'hB380_0000);
        push("in_t3", 32'hB380_0000, mk(16'h0000, 16'h0080, 8'h40, 9'h000, 0, 0, 0, 5'h00, 1, 0, 3'd3));
        // out R9
        fetch("out", 32'hBC80_0000);
        push("out_t3", 32'hBC80_0000, mk(16'h0200, 16'h0, 8'h00, 9'h040, 0, 0, 0, 5'h00, 1, 0, 3'd3));
        // mfhi R15
        fetch("mfhi", 32'hC780_0000);
        push("mfhi_t3", 32'hC780_0000, mk(16'h0000, 16'h8000, 8'h01, 9'h000, 0, 0, 0, 5'h00, 1, 0, 3'd3));
        // mflo R0
        fetch("mflo", 32'hC800_0000);
        push("mflo_t3", 32'hC800_0000, mk(16'h0000, 16'h0001, 8'h02, 9'h000, 0, 0, 0, 5'h00, 1, 0, 3'd3));
        fetch("nop", 32'hD000_0000);
        push("nop_t3", 32'hD000_0000, mk(16'h0, 16'h0, 8'h00, 9'h000, 0, 0, 0, 5'h00, 1, 0, 3'd3));
        // undefined opcode 10000
        fetch("undef", 32'h8000_0000);
        push("undef_t3", 32'h8000_0000, mk(16'h0, 16'h0, 8'h00, 9'h000, 0, 0, 0, 5'h00, 1, 1, 3'd3));
        // sub Ra=1 Rb=14 Rc=13
        fetch("sub", 32'h20F6_8000);
        push("sub_t3", 32'h20F6_8000, mk(16'h4000, 16'h0, 8'h00, 9'h080, 0, 0, 0, 5'h00, 1, 0, 3'd3));
        push("sub_t4", 32'h20F6_8000, mk(16'h2000, 16'h0, 8'h00, 9'h008, 0, 0, 0, 5'h04, 1, 0, 3'd4));
        push("sub_t5", 32'h20F6_8000, mk(16'h0000, 16'h0002, 8'h08, 9'h000, 0, 0, 0, 5'h00, 1, 0, 3'd5));
        push("next_t0", 32'h1910_0000, T0_EXP);

        clear     = 1'b1;
        BusMuxOut = '0;
        repeat (2) tick();
        check("clear_held", ZERO);
        clear = 1'b0;
        check("rst_state", ZERO);

        foreach (vecs[i]) begin
            BusMuxOut = vecs[i].bus;
            tick();
            check(vecs[i].name, vecs[i].exp);
        end

        // async clear in the middle of an add's T4
        BusMuxOut = 32'h1910_0000;
        repeat (4) tick();
        check("add2_t4", mk(16'h0001, 16'h0, 8'h00, 9'h008, 0, 0, 0, 5'h03, 1, 0, 3'd4));
        clear = 1'b1;
        #1;
        check("clear_async", ZERO);
        tick();
        check("clear_hold", ZERO);
        clear = 1'b0;
        check("clear_rst", ZERO);
        tick();
        check("clear_t0", T0_EXP);

        // halt then restart by clear
        BusMuxOut = 32'hD800_0000;
        tick();
        check("halt_t1", T1_EXP);
        tick();
        tick();
        check("halt_t3", mk(16'h0, 16'h0, 8'h00, 9'h000, 0, 0, 0, 5'h00, 1, 0, 3'd3));
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("halt_hold%0d", k), ZERO);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("halt_rst", ZERO);
        tick();
        check("halt_restart_t0", T0_EXP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
